// File: rtl/accum_host_ctrl.sv
// accum_host_ctrl: host-side sequencer for an accumulate kernel.
// It streams a job into the kernel array, kicks the kernel, waits for
// completion (with a cycle timeout), then streams the array back out.
//
// Handshake rule for both streams: a word moves on a cycle where valid and
// ready are both 1 at the rising clock edge. Valid never depends
// combinationally on ready, and ready never depends on valid. Once out_valid
// is raised it holds, with stable out_data, until the word is accepted.
module accum_host_ctrl #(
    parameter int          DEPTH   = 1000,
    parameter int          AW      = 10,
    parameter int          DW      = 64,
    parameter logic [31:0] TIMEOUT = 32'd100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AW-1:0]        len,
    input  logic [AW-1:0]        init_i,
    input  logic signed [DW-1:0] init_acc,
    input  logic                 in_valid,
    input  logic [DW-1:0]        in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 result,
    output logic [31:0]          cycles,
    output logic                 k_r_enable,
    output logic                 k_controlArr,
    output logic [AW-1:0]        k_init_i,
    output logic signed [DW-1:0] k_init_acc,
    output logic                 k_wen,
    output logic [AW-1:0]        k_addr,
    output logic [DW-1:0]        k_wdata,
    input  logic [DW-1:0]        k_rdata,
    input  logic                 k_w_enable,
    input  logic                 k_result
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_KICK  = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] len_q;
    logic          primed;
    logic          len_ok;
    logic          last_word;
    logic          load_hs;
    logic          out_hs;
    logic [31:0]   cycles_inc;

    assign len_ok     = (len != '0) && (32'(len) <= 32'(DEPTH));
    assign last_word  = (cnt == len_q - AW'(1));
    assign load_hs    = (state == S_LOAD) && in_valid;
    assign out_hs     = (state == S_DRAIN) && primed && out_ready;
    // Run counter saturates instead of wrapping.
    assign cycles_inc = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;

    // Next-state decode and all combinational outputs.
    always_comb begin
        state_nxt    = state;
        busy         = (state != S_IDLE);
        done         = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        k_r_enable   = 1'b0;
        k_controlArr = 1'b0;
        k_wen        = 1'b0;
        k_addr       = '0;
        k_wdata      = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = len_ok ? S_LOAD : S_FIN;
                end
            end
            S_LOAD: begin
                in_ready     = 1'b1;
                k_controlArr = 1'b1;
                if (load_hs) begin
                    k_wen   = 1'b1;
                    k_addr  = cnt;
                    k_wdata = in_data;
                    if (last_word) begin
                        state_nxt = S_KICK;
                    end
                end
            end
            S_KICK: begin
                k_r_enable = 1'b1;
                state_nxt  = S_RUN;
            end
            S_RUN: begin
                if (k_w_enable) begin
                    state_nxt = S_DRAIN;
                end else if (cycles_inc >= TIMEOUT) begin
                    state_nxt = S_FIN;
                end
            end
            S_DRAIN: begin
                k_controlArr = 1'b1;
                k_addr       = cnt;
                out_valid    = primed;
                out_data     = primed ? k_rdata : '0;
                if (out_hs && last_word) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register plus job bookkeeping: counters, latched job fields, status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            len_q      <= '0;
            primed     <= 1'b0;
            k_init_i   <= '0;
            k_init_acc <= '0;
            err        <= 1'b0;
            result     <= 1'b0;
            cycles     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            len_q      <= len;
                            k_init_i   <= init_i;
                            k_init_acc <= init_acc;
                            cnt        <= '0;
                            primed     <= 1'b0;
                            err        <= 1'b0;
                            cycles     <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (load_hs) begin
                        cnt <= cnt + AW'(1);
                    end
                end
                S_RUN: begin
                    cycles <= cycles_inc;
                    if (k_w_enable) begin
                        result <= k_result;
                        cnt    <= '0;
                        primed <= 1'b0;
                    end else if (cycles_inc >= TIMEOUT) begin
                        err <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    // The array read lags the address by one cycle, so data is
                    // only offered on the cycle after the address settles.
                    if (out_hs) begin
                        cnt    <= cnt + AW'(1);
                        primed <= 1'b0;
                    end else begin
                        primed <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_host_ctrl.sv
// tb_accum_host_ctrl: randomized job stimulus against a queue-based reference
// model, with a behavioural kernel stub (array memory, prefix-sum, completion).
module tb_accum_host_ctrl;

    localparam int          DEPTH = 1000;
    localparam int          AW    = 10;
    localparam int          DW    = 64;
    localparam logic [31:0] TO    = 32'd50;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                 start;
    logic [AW-1:0]        len;
    logic [AW-1:0]        init_i;
    logic signed [DW-1:0] init_acc;
    logic                 in_valid;
    logic [DW-1:0]        in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic                 out_ready;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic                 result;
    logic [31:0]          cycles;
    logic                 k_r_enable;
    logic                 k_controlArr;
    logic [AW-1:0]        k_init_i;
    logic signed [DW-1:0] k_init_acc;
    logic                 k_wen;
    logic [AW-1:0]        k_addr;
    logic [DW-1:0]        k_wdata;
    logic [DW-1:0]        k_rdata;
    logic                 k_w_enable;
    logic                 k_result;

    accum_host_ctrl #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .init_i(init_i),
        .init_acc(init_acc), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .done(done), .err(err),
        .result(result), .cycles(cycles), .k_r_enable(k_r_enable),
        .k_controlArr(k_controlArr), .k_init_i(k_init_i),
        .k_init_acc(k_init_acc), .k_wen(k_wen), .k_addr(k_addr),
        .k_wdata(k_wdata), .k_rdata(k_rdata), .k_w_enable(k_w_enable),
        .k_result(k_result)
    );

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    int            done_cnt = 0;
    int            kick_cnt = 0;
    int            ov_cnt   = 0;
    int            rd_cnt   = 0;
    int            ld_idx   = 0;
    int            stall_pct = 0;
    bit            stub_hang = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic          model_err    = 1'b0;
    logic          model_result = 1'b0;
    logic [31:0]   model_cycles = '0;
    logic          pend_err     = 1'b0;
    logic          pend_result  = 1'b0;
    logic [31:0]   pend_cycles  = '0;
    logic [AW-1:0] job_ii  = '0;
    logic [DW-1:0] job_acc = '0;
    logic [DW-1:0] mem [DEPTH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- kernel stub ----------------
    always @(posedge clk) k_rdata <= (k_addr < DEPTH) ? mem[k_addr] : '0;

    initial begin
        int            d;
        logic [DW-1:0] acc;
        k_w_enable = 1'b0;
        k_result   = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            if (rst_n && k_wen && k_addr < DEPTH) mem[k_addr] = k_wdata;
            if (rst_n && k_r_enable) begin
                kick_cnt++;
                chk("k_init_i", 64'(k_init_i), 64'(job_ii));
                chk("k_init_acc", k_init_acc, job_acc);
                if (!stub_hang) begin
                    d = $urandom_range(1, 12);
                    repeat (d) @(posedge clk);
                    #1;
                    acc = k_init_acc;
                    for (int i = int'(k_init_i); i < DEPTH; i++) begin
                        acc    = acc + mem[i];
                        mem[i] = acc;
                    end
                    k_result    = acc[0];
                    k_w_enable  = 1'b1;
                    pend_cycles = 32'(d);
                    pend_result = acc[0];
                    @(posedge clk);
                    #1;
                    k_w_enable = 1'b0;
                end
            end
        end
    end

    // ---------------- readback consumer ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(99) >= 32'(stall_pct));
        end
    end

    // ---------------- compare process ----------------
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_data", out_data, prev_data);
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                if (out_valid) ov_cnt++;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("readback_extra", 64'(exp_q.size()), 64'd1);
                    else chk("readback", out_data, exp_q.pop_front());
                    rd_cnt++;
                end
                chk("k_wen", 64'(k_wen), 64'(in_valid && in_ready));
                if (in_valid && in_ready) begin
                    chk("k_addr_load", 64'(k_addr), 64'(ld_idx));
                    chk("k_wdata", k_wdata, in_data);
                    ld_idx++;
                end else begin
                    chk("k_wdata_idle", k_wdata, 64'd0);
                end
                if (in_ready || out_valid) chk("k_controlArr", 64'(k_controlArr), 64'd1);
                if (!busy) begin
                    chk("idle_in_ready", 64'(in_ready), 64'd0);
                    chk("idle_out_valid", 64'(out_valid), 64'd0);
                    chk("idle_k_addr", 64'(k_addr), 64'd0);
                    chk("hold_err", 64'(err), 64'(model_err));
                    chk("hold_result", 64'(result), 64'(model_result));
                    chk("hold_cycles", 64'(cycles), 64'(model_cycles));
                end
                if (done) begin
                    done_cnt++;
                    model_err    = pend_err;
                    model_result = pend_result;
                    model_cycles = pend_cycles;
                    chk("done_err", 64'(err), 64'(model_err));
                    chk("done_result", 64'(result), 64'(model_result));
                    chk("done_cycles", 64'(cycles), 64'(model_cycles));
                    chk("done_busy", 64'(busy), 64'd1);
                    if (!pend_err) chk("readback_left", 64'(exp_q.size()), 64'd0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_flags", 64'({busy, done, err, result, in_ready, out_valid,
                              k_r_enable, k_controlArr, k_wen}), 64'd0);
        chk("rst_cycles", 64'(cycles), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_k_addr", 64'(k_addr), 64'd0);
        chk("rst_k_wdata", k_wdata, 64'd0);
        chk("rst_k_init_i", 64'(k_init_i), 64'd0);
        chk("rst_k_init_acc", k_init_acc, 64'd0);
        exp_q.delete();
        model_err = 1'b0; model_result = 1'b0; model_cycles = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // mode 0: all ones, 1: 10,20,30..., 2: random words
    task automatic run_job(input int n, input int ii, input logic [DW-1:0] acc0,
                           input int gap, input int stall, input int mode,
                           input int abort_after, input bit hang);
        logic [DW-1:0] ld[$];
        logic [DW-1:0] run;
        logic [DW-1:0] pin [4];
        int            idx, budget, d0, ov0;
        bit            hs;
        pin[0] = 64'd10; pin[1] = 64'd30; pin[2] = 64'd60; pin[3] = 64'd100;
        exp_q.delete();
        run = acc0;
        for (int j = 0; j < n; j++) begin
            case (mode)
                0:       ld.push_back(64'd1);
                1:       ld.push_back(64'(10 * (j + 1)));
                default: ld.push_back({$urandom, $urandom});
            endcase
            if (j >= ii) run = run + ld[j];
            exp_q.push_back((j < ii) ? ld[j] : run);
        end
        if (mode == 0) chk("model_pin_ones", exp_q[n-1], 64'(n));
        if (mode == 1 && n == 4) begin
            for (int j = 0; j < 4; j++) chk("model_pin_10_20_30_40", exp_q[j], pin[j]);
        end
        pend_err = hang; pend_cycles = TO; pend_result = model_result;
        if (hang) begin
            exp_q.delete();
            stub_hang = 1'b1;
        end
        job_ii = AW'(ii); job_acc = acc0; ld_idx = 0; rd_cnt = 0; stall_pct = stall;
        d0 = done_cnt; ov0 = ov_cnt;
        start = 1'b1; len = AW'(n); init_i = AW'(ii); init_acc = acc0;
        idx = 0; budget = 0;
        while (idx < n && budget < 10000) begin
            in_valid = ($urandom_range(99) >= 32'(gap));
            in_data  = ld[idx];
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (hs) idx++;
            budget++;
        end
        in_valid = 1'b0; in_data = '0; start = 1'b0;
        if (idx < n) chk("load_stalled", 64'(idx), 64'(n));
        budget = 0;
        while (done_cnt == d0 && budget < 20000 && !(abort_after > 0 && rd_cnt >= abort_after)) begin
            @(negedge clk);
            budget++;
        end
        @(posedge clk);
        #1;
        if (budget >= 20000) chk("done_timeout", 64'(budget), 64'd0);
        if (abort_after > 0) begin
            do_reset();
            repeat (4) @(posedge clk);
            #1;
            chk("abort_no_done", 64'(done_cnt), 64'(d0));
        end else begin
            repeat (2) @(posedge clk);
            #1;
            chk("done_pulses", 64'(done_cnt), 64'(d0 + 1));
            if (hang) begin
                chk("timeout_cycles", 64'(cycles), 64'd50);
                chk("timeout_err", 64'(err), 64'd1);
                chk("timeout_no_out", 64'(ov_cnt), 64'(ov0));
            end
        end
        stub_hang = 1'b0;
        stall_pct = 0;
    endtask

    task automatic bad_start(input int n);
        int d0, k0;
        pend_err = 1'b1; pend_cycles = model_cycles; pend_result = model_result;
        d0 = done_cnt; k0 = kick_cnt;
        start = 1'b1; len = AW'(n); init_i = '0; init_acc = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("bad_len_done", 64'(done), 64'd1);
        chk("bad_len_err", 64'(err), 64'd1);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("bad_len_one_done", 64'(done_cnt), 64'(d0 + 1));
        chk("bad_len_no_kick", 64'(kick_cnt), 64'(k0));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n, ii;
        start = 1'b0; len = '0; init_i = '0; init_acc = '0;
        in_valid = 1'b0; in_data = '0;
        do_reset();
        run_job(1000, 0, 64'd0, 0, 0, 0, 0, 1'b0);     // ones, start right after reset
        run_job(4, 0, 64'd0, 0, 0, 1, 0, 1'b0);        // 10,20,30,40
        bad_start(0);
        bad_start(1001);
        run_job(1000, 0, 64'd0, 50, 50, 0, 0, 1'b0);   // gaps and stalls
        run_job(6, 0, 64'd0, 0, 0, 2, 0, 1'b1);        // kernel never completes
        run_job(1, 0, {$urandom, $urandom}, 0, 30, 2, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n  = $urandom_range(2, 40);
            ii = $urandom_range(0, n - 1);
            run_job(n, ii, {$urandom, $urandom}, $urandom_range(0, 60),
                    $urandom_range(0, 60), 2, 0, 1'b0);
        end
        run_job(8, 0, 64'd0, 0, 0, 1, 3, 1'b0);        // reset mid-readback
        run_job(4, 0, 64'd0, 0, 0, 1, 0, 1'b0);        // fresh job after abort
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
